neuron_feeder: RTL and testbench
================================

Name: neuron_feeder

Overview:
Sequencer that drives a single MAC neuron (w/x/b inputs, inptReady strobe, active-high sync rst, combinational out).
- Holds a K-entry weight/input buffer loaded through a write port.
- On start, clears the neuron, streams len (w,x) pairs with inptReady high, then runs the one bias cycle.
- Captures the neuron output and presents it on a valid/ready result handshake.
- It is the initiator side of the neuron's streaming interface, one per neuron in a layer.

Parameters:
N, 10, data width (signed fixed point, sign + N-1 bits)
Q, 9, fractional bits (must match the driven neuron)
K, 8, buffer depth (maximum inputs per neuron)
AW, 3, address/length index width, ceil(log2(K)); len port is AW+1 bits

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset (0 = reset asserted)
load_we  in  1  write strobe for buffer entry load_addr
load_addr  in  AW  buffer index, 0..K-1
load_w  in  N  signed weight written at load_addr
load_x  in  N  signed input written at load_addr
start  in  1  begin evaluation; sampled only in IDLE
len  in  AW+1  number of pairs to stream, 0..K; sampled with start
b_in  in  N  signed bias; sampled with start
busy  out  1  high in every state except IDLE
n_rst  out  1  active-high sync reset to neuron
n_inptReady  out  1  neuron input strobe
n_w  out  N  weight to neuron
n_x  out  N  input to neuron
n_b  out  N  bias to neuron (registered copy of b_in)
n_out  in  N  neuron output
result  out  N  captured neuron output
result_valid  out  1  result available
result_ready  in  1  consumer accepts result

Behaviour:
- Reset (async, rst=0):
  - state=IDLE; busy=0; result=0; result_valid=0.
  - n_rst=1; n_inptReady=0; n_w=n_x=n_b=0; idx=0.
  - Buffer contents are not reset.
- Buffer writes:
  - Accepted only in IDLE. load_we in any other state is ignored; contents are unchanged.
  - load_addr >= K is ignored.
- FSM states: IDLE, CLEAR, STREAM, BIAS, CAPTURE, DONE.
- IDLE:
  - n_rst=1, n_inptReady=0.
  - start=1 latches len and b_in (len>K is clamped to K) and moves to CLEAR.
- CLEAR: one cycle, n_rst=1. Next state is STREAM with idx=0, or BIAS if len=0.
- STREAM:
  - n_rst=0, n_inptReady=1, n_w=w[idx], n_x=x[idx].
  - idx increments each cycle; after the cycle with idx=len-1, go to BIAS.
  - Exactly len strobe cycles, no gaps.
- BIAS:
  - One cycle, n_rst=0, n_inptReady=0, n_b held.
  - The neuron adds b<<Q on this edge.
- CAPTURE: one cycle; result <= n_out.
- DONE:
  - result_valid=1, n_rst=0 (neuron holds its value); result is stable.
  - result_valid & result_ready moves to IDLE; result_valid falls on that edge.
  - start in DONE is ignored.
- Latency: start sampled at edge E0; result_valid rises at edge E(len+3).
- Outputs to the neuron are registered (driven from state/idx flops), not decoded combinationally from inputs.
- n_b is driven from the latched bias throughout the evaluation and holds until the next start.
- Arithmetic: the feeder performs none. It forwards values bit-exact; result is n_out captured unchanged.
- Reset mid-operation:
  - Immediate return to IDLE, and n_rst reasserts asynchronously.
  - Any partial result is discarded; the next start produces a correct result.

Test Plan:
- Load w[0]=256,w[1]=256,x[0]=256,x[1]=128; start with len=2, b_in=64.
  - n_inptReady is high exactly 2 cycles with pairs (256,256),(256,128).
  - result_valid rises at E5; result=256 (0.5).
- len=0, b_in=-128: no inptReady cycles; result=-128 (10'h380) at E3.
- len=8, all w=x=128, b_in=0 -> result=256; n_inptReady high 8 consecutive cycles.
- Hold result_ready=0 for 5 cycles in DONE while pulsing start and load_we.
  - result and result_valid stay stable; buffer contents are unchanged; no new evaluation starts.
  - result_ready=1 -> IDLE next cycle, busy=0.
- Assert rst=0 during STREAM idx=3.
  - Outputs go to reset values immediately.
  - Rerun of the first scenario yields result=256.
- Back-to-back: accept a result and assert start on the next IDLE cycle. The second result is correct and independent of the first.

Source files
------------

// File: rtl/neuron_feeder.sv
// neuron_feeder: sequencer on the initiator side of a single MAC neuron's stream.
// It keeps a K-entry (w,x) buffer loaded through a write port. On start it clears
// the neuron, streams len pairs with n_inptReady high, runs one bias cycle, then
// captures n_out and offers it on a valid/ready result handshake.
//
// Ports:
//   clk, rst                  clock; asynchronous active-low reset (0 = asserted)
//   load_we/addr/w/x          buffer write port, honoured only while idle
//   start, len, b_in          begin an evaluation of len pairs (clamped to K) with bias b_in
//   busy                      high whenever not idle
//   n_rst, n_inptReady        neuron sync clear and input strobe
//   n_w, n_x, n_b             neuron operands; n_b is the bias latched at start
//   n_out                     neuron output (combinational on the neuron side)
//   result, result_valid,     captured neuron output and its handshake
//   result_ready
module neuron_feeder #(
  parameter int unsigned N  = 10,
  parameter int unsigned Q  = 9,
  parameter int unsigned K  = 8,
  parameter int unsigned AW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_we,
  input  logic [AW-1:0] load_addr,
  input  logic [N-1:0]  load_w,
  input  logic [N-1:0]  load_x,
  input  logic          start,
  input  logic [AW:0]   len,
  input  logic [N-1:0]  b_in,
  output logic          busy,
  output logic          n_rst,
  output logic          n_inptReady,
  output logic [N-1:0]  n_w,
  output logic [N-1:0]  n_x,
  output logic [N-1:0]  n_b,
  input  logic [N-1:0]  n_out,
  output logic [N-1:0]  result,
  output logic          result_valid,
  input  logic          result_ready
);

  // Parameter sanity: Q is a contract with the driven neuron, the buffer must fit AW.
  if (Q >= N || K < 1 || K > (1 << AW)) begin : g_cfg_check
    $error("neuron_feeder: inconsistent parameters (need Q < N and 1 <= K <= 2**AW)");
  end

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CLEAR   = 3'd1;
  localparam logic [2:0] S_STREAM  = 3'd2;
  localparam logic [2:0] S_BIAS    = 3'd3;
  localparam logic [2:0] S_CAPTURE = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  localparam logic [AW:0] LEN_MAX = (AW+1)'(K);
  localparam logic [AW:0] IDX_ONE = (AW+1)'(1);

  // Weight/input buffer; contents deliberately survive reset.
  logic [N-1:0] w_mem [K];
  logic [N-1:0] x_mem [K];

  logic [2:0]   state_q, state_d;
  logic [AW:0]  idx_q, idx_d;
  logic [AW:0]  len_q, len_d;
  logic [N-1:0] b_q, b_d;
  logic [N-1:0] result_q, result_d;

  logic         busy_q, busy_d;
  logic         n_rst_q, n_rst_d;
  logic         n_inpt_ready_q, n_inpt_ready_d;
  logic [N-1:0] n_w_q, n_w_d;
  logic [N-1:0] n_x_q, n_x_d;
  logic         result_valid_q, result_valid_d;

  logic         load_ok;

  // Buffer writes only land while idle and in range.
  assign load_ok = load_we && (state_q == S_IDLE) && ({1'b0, load_addr} < LEN_MAX);

  always_ff @(posedge clk) begin
    if (load_ok) begin
      w_mem[load_addr] <= load_w;
      x_mem[load_addr] <= load_x;
    end
  end

  // Next-state and next-output logic; outputs are decoded from the next state so
  // the registered copies line up with the state they describe.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    len_d          = len_q;
    b_d            = b_q;
    result_d       = result_q;
    busy_d         = 1'b0;
    n_rst_d        = 1'b1;
    n_inpt_ready_d = 1'b0;
    n_w_d          = '0;
    n_x_d          = '0;
    result_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d   = (len > LEN_MAX) ? LEN_MAX : len;
          b_d     = b_in;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        idx_d   = '0;
        state_d = (len_q == '0) ? S_BIAS : S_STREAM;
      end
      S_STREAM: begin
        idx_d = idx_q + IDX_ONE;
        // Leave after the cycle that presented entry len-1.
        if (idx_q + IDX_ONE == len_q) begin
          state_d = S_BIAS;
        end
      end
      S_BIAS: begin
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        // The neuron took the bias on the previous edge, so n_out is final here.
        result_d = n_out;
        state_d  = S_DONE;
      end
      S_DONE: begin
        if (result_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d         = (state_d != S_IDLE);
    n_rst_d        = (state_d == S_IDLE) || (state_d == S_CLEAR);
    n_inpt_ready_d = (state_d == S_STREAM);
    result_valid_d = (state_d == S_DONE);
    if (state_d == S_STREAM) begin
      n_w_d = w_mem[idx_d[AW-1:0]];
      n_x_d = x_mem[idx_d[AW-1:0]];
    end
  end

  // State, sequencing and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      idx_q          <= '0;
      len_q          <= '0;
      b_q            <= '0;
      result_q       <= '0;
      busy_q         <= 1'b0;
      n_rst_q        <= 1'b1;
      n_inpt_ready_q <= 1'b0;
      n_w_q          <= '0;
      n_x_q          <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      len_q          <= len_d;
      b_q            <= b_d;
      result_q       <= result_d;
      busy_q         <= busy_d;
      n_rst_q        <= n_rst_d;
      n_inpt_ready_q <= n_inpt_ready_d;
      n_w_q          <= n_w_d;
      n_x_q          <= n_x_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign busy         = busy_q;
  assign n_rst        = n_rst_q;
  assign n_inptReady  = n_inpt_ready_q;
  assign n_w          = n_w_q;
  assign n_x          = n_x_q;
  assign n_b          = b_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;

endmodule

// File: tb/tb_neuron_feeder.sv
// Bench for neuron_feeder: a behavioural MAC neuron answers the feeder, a monitor
// logs every strobed (w,x) pair, and expected results come from a plain-arithmetic
// dot product over a shadow copy of the buffer.
module tb_neuron_feeder;

  localparam int N = 10;
  localparam int Q = 9;
  localparam int K = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         load_we = 1'b0;
  logic [2:0]   load_addr = '0;
  logic [N-1:0] load_w = '0;
  logic [N-1:0] load_x = '0;
  logic         start = 1'b0;
  logic [3:0]   len = '0;
  logic [N-1:0] b_in = '0;
  logic         busy, n_rst, n_inptReady, result_valid;
  logic         result_ready = 1'b0;
  logic [N-1:0] n_w, n_x, n_b, n_out, result;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  neuron_feeder #(.N(N), .Q(Q), .K(K), .AW(3)) dut (
    .clk(clk), .rst(rst),
    .load_we(load_we), .load_addr(load_addr), .load_w(load_w), .load_x(load_x),
    .start(start), .len(len), .b_in(b_in),
    .busy(busy), .n_rst(n_rst), .n_inptReady(n_inptReady),
    .n_w(n_w), .n_x(n_x), .n_b(n_b), .n_out(n_out),
    .result(result), .result_valid(result_valid), .result_ready(result_ready)
  );

  // Behavioural neuron: accumulates products at 2Q fraction, adds b<<Q once after the stream.
  longint acc = 0;
  bit     bias_done = 1'b0;
  assign n_out = N'(acc >>> Q);

  always @(posedge clk) begin
    if (n_rst) begin
      acc       <= 0;
      bias_done <= 1'b0;
    end else if (n_inptReady) begin
      acc <= acc + longint'($signed(n_w)) * longint'($signed(n_x));
    end else if (!bias_done) begin
      acc       <= acc + (longint'($signed(n_b)) <<< Q);
      bias_done <= 1'b1;
    end
  end

  // Monitor of strobed pairs with their edge numbers.
  int           cyc = 0;
  logic [N-1:0] pw[$];
  logic [N-1:0] px[$];
  int           ps[$];

  always @(posedge clk) begin
    if (n_inptReady) begin
      pw.push_back(n_w);
      px.push_back(n_x);
      ps.push_back(cyc);
    end
    cyc <= cyc + 1;
  end

  // Shadow of the buffer contents.
  logic signed [N-1:0] mw [K];
  logic signed [N-1:0] mx [K];

  function automatic logic [N-1:0] ref_result(input int l, input logic [N-1:0] b);
    longint s = 0;
    int     lc = (l > K) ? K : l;
    for (int i = 0; i < lc; i++) s += longint'(mw[i]) * longint'(mx[i]);
    s += longint'($signed(b)) * (longint'(1) <<< Q);
    return N'(s >>> Q);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int a, input logic [N-1:0] w, input logic [N-1:0] x);
    load_we = 1'b1; load_addr = 3'(a); load_w = w; load_x = x;
    tick();
    load_we = 1'b0;
    mw[a] = w;
    mx[a] = x;
  endtask

  task automatic accept();
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
  endtask

  // One evaluation: latency, strobe count/contiguity, pair contents, n_b and result.
  task automatic run_and_check(input string nm, input int l, input logic [N-1:0] b,
                               output logic [N-1:0] res);
    int  lat = 0;
    bit  to = 1'b1;
    int  lc = (l > K) ? K : l;
    logic [N-1:0] want = ref_result(l, b);
    pw.delete(); px.delete(); ps.delete();
    len = 4'(l); b_in = b; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (result_valid === 1'b1) begin
        lat = k;
        to  = 1'b0;
        break;
      end
    end
    res = result;
    n_vec++;
    if (to !== 1'b0) begin
      n_err++; $display("FAIL %s timeout: result_valid never rose within 40 cycles", nm);
    end
    n_vec++;
    if (lat !== lc + 3) begin
      n_err++; $display("FAIL %s latency: got %0d want %0d", nm, lat, lc + 3);
    end
    n_vec++;
    if (res !== want) begin
      n_err++; $display("FAIL %s result: got %h want %h", nm, res, want);
    end
    n_vec++;
    if (pw.size() !== lc) begin
      n_err++; $display("FAIL %s strobes: got %0d want %0d", nm, pw.size(), lc);
    end
    for (int i = 0; i < pw.size() && i < K; i++) begin
      n_vec++;
      if ({pw[i], px[i]} !== {mw[i], mx[i]}) begin
        n_err++;
        $display("FAIL %s pair%0d: got (%h,%h) want (%h,%h)", nm, i, pw[i], px[i], mw[i], mx[i]);
      end
    end
    if (ps.size() > 0) begin
      n_vec++;
      if (ps[ps.size()-1] - ps[0] !== ps.size() - 1) begin
        n_err++; $display("FAIL %s gap: span %0d for %0d strobes", nm, ps[ps.size()-1] - ps[0], ps.size());
      end
    end
    n_vec++;
    if (n_b !== b) begin
      n_err++; $display("FAIL %s n_b: got %h want %h", nm, n_b, b);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2 rst = 1'b0;
    tick(); tick();
    n_vec++;
    if ({busy, result_valid, n_rst, n_inptReady} !== 4'b0010) begin
      n_err++; $display("FAIL reset_ctrl: got %b want 0010", {busy, result_valid, n_rst, n_inptReady});
    end
    n_vec++;
    if ({result, n_w, n_x, n_b} !== 40'd0) begin
      n_err++; $display("FAIL reset_data: got %h want 0", {result, n_w, n_x, n_b});
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [N-1:0] res;
    load(0, 10'd256, 10'd256);
    load(1, 10'd256, 10'd128);
    run_and_check("basic", 2, 10'd64, res);
    n_vec++;
    if (res !== 10'd256) begin
      n_err++; $display("FAIL basic_const: got %h want 100", res);
    end
    accept();
    n_vec++;
    if ({busy, result_valid} !== 2'b00) begin
      n_err++; $display("FAIL basic_idle: busy/valid got %b want 00", {busy, result_valid});
    end
  endtask

  task automatic test_zero_len();
    logic [N-1:0] res;
    run_and_check("len0", 0, 10'h380, res);
    n_vec++;
    if (res !== 10'h380) begin
      n_err++; $display("FAIL len0_const: got %h want 380", res);
    end
    accept();
  endtask

  task automatic test_full_len();
    logic [N-1:0] res;
    for (int i = 0; i < K; i++) load(i, 10'd128, 10'd128);
    run_and_check("full", 8, 10'd0, res);
    n_vec++;
    if (res !== 10'd256) begin
      n_err++; $display("FAIL full_const: got %h want 100", res);
    end
    accept();
    run_and_check("clamp", 15, 10'd0, res);
    n_vec++;
    if (res !== 10'd256) begin
      n_err++; $display("FAIL clamp_const: got %h want 100", res);
    end
    accept();
  endtask

  task automatic test_done_hold();
    logic [N-1:0] res;
    run_and_check("hold", 3, 10'd7, res);
    pw.delete();
    for (int c = 0; c < 5; c++) begin
      result_ready = 1'b0; start = 1'b1; len = 4'd2;
      load_we = 1'b1; load_addr = 3'(c); load_w = ~mw[c]; load_x = ~mx[c];
      tick();
      n_vec++;
      if ({result_valid, busy, result} !== {2'b11, res}) begin
        n_err++; $display("FAIL hold_c%0d: valid/busy/result got %b%b/%h want 11/%h", c, result_valid, busy, result, res);
      end
    end
    start = 1'b0; load_we = 1'b0;
    n_vec++;
    if (pw.size() !== 0) begin
      n_err++; $display("FAIL hold_nostream: got %0d strobes want 0", pw.size());
    end
    accept();
    n_vec++;
    if ({busy, result_valid} !== 2'b00) begin
      n_err++; $display("FAIL hold_release: busy/valid got %b want 00", {busy, result_valid});
    end
    run_and_check("hold_rerun", 8, 10'd0, res);
    accept();
  endtask

  task automatic test_reset_midstream();
    logic [N-1:0] res;
    len = 4'd8; b_in = 10'd5; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    n_vec++;
    if ({n_inptReady, n_w} !== {1'b1, mw[3]}) begin
      n_err++; $display("FAIL mid_idx3: strobe/w got %b/%h want 1/%h", n_inptReady, n_w, mw[3]);
    end
    rst = 1'b0;
    #1;
    n_vec++;
    if ({busy, result_valid, n_rst, n_inptReady} !== 4'b0010) begin
      n_err++; $display("FAIL mid_rst_ctrl: got %b want 0010", {busy, result_valid, n_rst, n_inptReady});
    end
    n_vec++;
    if ({result, n_w, n_x, n_b} !== 40'd0) begin
      n_err++; $display("FAIL mid_rst_data: got %h want 0", {result, n_w, n_x, n_b});
    end
    tick();
    rst = 1'b1;
    tick();
    load(0, 10'd256, 10'd256);
    load(1, 10'd256, 10'd128);
    run_and_check("mid_rerun", 2, 10'd64, res);
    n_vec++;
    if (res !== 10'd256) begin
      n_err++; $display("FAIL mid_rerun_const: got %h want 100", res);
    end
    accept();
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] r1, r2;
    run_and_check("b2b_a", 8, 10'h3fd, r1);
    accept();
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL b2b_idle: busy got %b want 0", busy);
    end
    run_and_check("b2b_b", 2, 10'd64, r2);
    accept();
  endtask

  task automatic test_random();
    logic [N-1:0] res;
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < K; i++) load(i, 10'($urandom), 10'($urandom));
      run_and_check($sformatf("rand%0d", it), int'($urandom_range(0, 15)), 10'($urandom), res);
      accept();
      n_vec++;
      if ({busy, result_valid} !== 2'b00) begin
        n_err++; $display("FAIL rand%0d_idle: busy/valid got %b want 00", it, {busy, result_valid});
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_full_len();
    test_done_hold();
    test_reset_midstream();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
